// File: rtl/change_logger.sv
`default_nettype none
// ============================================================================
// change_logger - N-channel value-change monitor with arbitrated event FIFO.
// Optional macro CHANGE_LOGGER_TIMESTAMP_EN adds a 16-bit ev_ts stamp. Rev 1.0
// ============================================================================
module change_logger #(
    parameter  int W     = 6,
    parameter  int N     = 3,
    parameter  int DEPTH = 8,
    localparam int CW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N*W-1:0]           ch_val,
    input  logic [N-1:0]             ch_en,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [CW-1:0]            ev_chan,
    output logic [W-1:0]             ev_old,
    output logic [W-1:0]             ev_new,
    output logic [$clog2(DEPTH):0]   ev_count,
    output logic [7:0]               drop_cnt,
    output logic                     busy
`ifdef CHANGE_LOGGER_TIMESTAMP_EN
    ,
    output logic [15:0]              ev_ts
`endif
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int DW   = $clog2(N + 1);
`ifdef CHANGE_LOGGER_TIMESTAMP_EN
    localparam int TSW  = 16;
`else
    localparam int TSW  = 0;
`endif
    localparam int EW   = CW + 2 * W + TSW;

    logic [N-1:0][W-1:0]     w_val;
    logic [N-1:0][W-1:0]     shadow_q;
    logic [N-1:0][W-1:0]     pold_q, pold_d;
    logic [N-1:0][W-1:0]     pnew_q, pnew_d;
    logic [N-1:0]            pend_q, pend_d;
    logic [N-1:0]            w_chg, w_deq;
    logic [7:0]              drop_q, drop_d;
    logic [DW-1:0]           w_ndrop;
    logic [8:0]              w_drop_sum;
    logic [DEPTH-1:0][EW-1:0] mem_q;
    logic [AW-1:0]           wr_q, rd_q;
    logic [CNTW-1:0]         count_q, count_d;
    logic                    w_enq, w_pop, w_full;
    logic [CW-1:0]           w_win;
    logic [W-1:0]            w_win_old, w_win_new;
    logic [EW-1:0]           w_entry, w_head;
`ifdef CHANGE_LOGGER_TIMESTAMP_EN
    logic [15:0]             tsc_q;
    logic [N-1:0][15:0]      pts_q, pts_d;
    logic [15:0]             w_win_ts;
`endif

    assign w_val  = ch_val;
    assign w_full = (count_q == CNTW'(DEPTH));
    assign w_pop  = ev_valid & ev_ready;
    // A full FIFO still accepts an entry when the head leaves on the same edge.
    assign w_enq  = (|pend_q) & (~w_full | w_pop);

    always_comb begin
        w_win     = '0;
        w_win_old = '0;
        w_win_new = '0;
`ifdef CHANGE_LOGGER_TIMESTAMP_EN
        w_win_ts  = '0;
`endif
        for (int i = N - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                w_win     = CW'(i);
                w_win_old = pold_q[i];
                w_win_new = pnew_q[i];
`ifdef CHANGE_LOGGER_TIMESTAMP_EN
                w_win_ts  = pts_q[i];
`endif
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            assign w_chg[gi] = (w_val[gi] != shadow_q[gi]);
            assign w_deq[gi] = w_enq && (w_win == CW'(gi));
        end
    endgenerate

    always_comb begin
        pend_d  = pend_q;
        pold_d  = pold_q;
        pnew_d  = pnew_q;
        w_ndrop = '0;
`ifdef CHANGE_LOGGER_TIMESTAMP_EN
        pts_d   = pts_q;
`endif
        for (int i = 0; i < N; i++) begin
            if (w_chg[i] && ch_en[i]) begin
                pnew_d[i] = w_val[i];
                if (w_deq[i]) begin
                    // Back-to-back change: the value just enqueued becomes the new old.
                    pold_d[i] = pnew_q[i];
`ifdef CHANGE_LOGGER_TIMESTAMP_EN
                    pts_d[i]  = tsc_q;
`endif
                end else if (!pend_q[i]) begin
                    pend_d[i] = 1'b1;
                    pold_d[i] = shadow_q[i];
`ifdef CHANGE_LOGGER_TIMESTAMP_EN
                    pts_d[i]  = tsc_q;
`endif
                end else begin
                    w_ndrop = w_ndrop + DW'(1);
                end
            end else if (w_deq[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    assign w_drop_sum = {1'b0, drop_q} + 9'(w_ndrop);
    assign drop_d     = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];

    always_comb begin
        count_d = count_q;
        if (w_enq && !w_pop) begin
            count_d = count_q + CNTW'(1);
        end else if (!w_enq && w_pop) begin
            count_d = count_q - CNTW'(1);
        end
    end

`ifdef CHANGE_LOGGER_TIMESTAMP_EN
    assign w_entry = {w_win, w_win_old, w_win_new, w_win_ts};
`else
    assign w_entry = {w_win, w_win_old, w_win_new};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            pend_q   <= '0;
            pold_q   <= '0;
            pnew_q   <= '0;
            drop_q   <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
`ifdef CHANGE_LOGGER_TIMESTAMP_EN
            tsc_q    <= '0;
            pts_q    <= '0;
`endif
        end else begin
            shadow_q <= w_val;
            pend_q   <= pend_d;
            pold_q   <= pold_d;
            pnew_q   <= pnew_d;
            drop_q   <= drop_d;
            count_q  <= count_d;
            if (w_enq) begin
                wr_q <= wr_q + AW'(1);
            end
            if (w_pop) begin
                rd_q <= rd_q + AW'(1);
            end
`ifdef CHANGE_LOGGER_TIMESTAMP_EN
            tsc_q    <= tsc_q + 16'd1;
            pts_q    <= pts_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            mem_q[wr_q] <= w_entry;
        end
    end

    assign w_head   = mem_q[rd_q];
    assign ev_valid = (count_q != '0);
    assign ev_count = count_q;
    assign drop_cnt = drop_q;
    assign busy     = (|pend_q) | ev_valid;
    assign ev_chan  = ev_valid ? w_head[EW-1 -: CW]      : '0;
    assign ev_old   = ev_valid ? w_head[2*W+TSW-1 -: W]  : '0;
    assign ev_new   = ev_valid ? w_head[W+TSW-1 -: W]    : '0;
`ifdef CHANGE_LOGGER_TIMESTAMP_EN
    assign ev_ts    = ev_valid ? w_head[15:0]            : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_change_logger.sv
`default_nettype none
// tb_change_logger: directed and randomized stimulus against a queue-based
// reference model of the change logger, compared on every falling edge.
module tb_change_logger;
    localparam int W     = 6;
    localparam int N     = 3;
    localparam int DEPTH = 8;
    localparam int CW    = 2;

    logic                   clk      = 1'b0;
    logic                   rst      = 1'b0;
    logic [N*W-1:0]         ch_val   = '0;
    logic [N-1:0]           ch_en    = '1;
    logic                   ev_ready = 1'b0;
    logic                   ev_valid;
    logic [CW-1:0]          ev_chan;
    logic [W-1:0]           ev_old, ev_new;
    logic [$clog2(DEPTH):0] ev_count;
    logic [7:0]             drop_cnt;
    logic                   busy;
`ifdef CHANGE_LOGGER_TIMESTAMP_EN
    logic [15:0]            ev_ts;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    change_logger #(.W(W), .N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .ch_val(ch_val), .ch_en(ch_en),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_chan(ev_chan),
        .ev_old(ev_old), .ev_new(ev_new), .ev_count(ev_count),
        .drop_cnt(drop_cnt), .busy(busy)
`ifdef CHANGE_LOGGER_TIMESTAMP_EN
        , .ev_ts(ev_ts)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {int ch; int o; int n; int ts;} ev_t;
    ev_t mq[$];
    int  msh[N], mold[N], mnew[N], mts[N];
    bit  mpend[N];
    int  mdrop, mcyc, m_win, m_v;
    bit  m_enq, m_pop;
    ev_t m_e;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            for (int i = 0; i < N; i++) begin
                msh[i] = 0; mold[i] = 0; mnew[i] = 0; mts[i] = 0; mpend[i] = 1'b0;
            end
            mdrop = 0;
            mcyc  = 0;
        end else begin
            m_pop = (mq.size() > 0) && ev_ready;
            m_win = -1;
            for (int i = 0; i < N; i++) if (mpend[i] && m_win < 0) m_win = i;
            m_enq = (m_win >= 0) && ((mq.size() < DEPTH) || m_pop);
            if (m_pop) void'(mq.pop_front());
            if (m_enq) begin
                m_e.ch = m_win; m_e.o = mold[m_win]; m_e.n = mnew[m_win]; m_e.ts = mts[m_win];
                mq.push_back(m_e);
            end
            for (int i = 0; i < N; i++) begin
                m_v = int'(ch_val[i*W +: W]);
                if (m_v != msh[i] && ch_en[i]) begin
                    if (m_enq && i == m_win) begin
                        mold[i] = mnew[i]; mnew[i] = m_v; mts[i] = mcyc;
                    end else if (!mpend[i]) begin
                        mpend[i] = 1'b1; mold[i] = msh[i]; mnew[i] = m_v; mts[i] = mcyc;
                    end else begin
                        mnew[i] = m_v;
                        if (mdrop < 255) mdrop++;
                    end
                end else if (m_enq && i == m_win) begin
                    mpend[i] = 1'b0;
                end
                msh[i] = m_v;
            end
            mcyc = (mcyc + 1) & 16'hFFFF;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit c_pend;
    always @(negedge clk) begin
        if (chk_on) begin
            c_pend = 1'b0;
            for (int i = 0; i < N; i++) c_pend |= mpend[i];
            chk("valid", ev_valid, int'(mq.size() != 0));
            chk("count", ev_count, mq.size());
            chk("drop",  drop_cnt, mdrop);
            chk("busy",  busy, int'(c_pend || mq.size() != 0));
            if (mq.size() != 0) begin
                chk("chan", ev_chan, mq[0].ch);
                chk("old",  ev_old,  mq[0].o);
                chk("new",  ev_new,  mq[0].n);
`ifdef CHANGE_LOGGER_TIMESTAMP_EN
                chk("ts",   ev_ts,   mq[0].ts);
`endif
            end else begin
                chk("chan_idle", ev_chan, 0);
                chk("old_idle",  ev_old,  0);
                chk("new_idle",  ev_new,  0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic setch(input int i, input int v);
        ch_val[i*W +: W] = W'(v);
    endtask

    int n_ev, last_o, last_n;
    bit done;

    initial begin
        #1 rst = 1'b1;
        chk_on = 1'b1;
        #1;
        chk("lit_rst_valid", ev_valid, 0);
        chk("lit_rst_count", ev_count, 0);
        chk("lit_rst_drop",  drop_cnt, 0);
        chk("lit_rst_busy",  busy, 0);
        setch(0, 3); setch(1, 4); setch(2, 5);
        ch_en = '1; ev_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // three simultaneous changes drain in ascending order
        @(posedge clk);
        @(negedge clk);
        chk("lit_s1_valid0", ev_valid, 0);
        chk("lit_s1_busy0",  busy, 1);
        @(negedge clk);
        chk("lit_s1_chan0", ev_chan, 0); chk("lit_s1_new0", ev_new, 3); chk("lit_s1_old0", ev_old, 0);
        @(negedge clk);
        chk("lit_s1_chan1", ev_chan, 1); chk("lit_s1_new1", ev_new, 4);
        @(negedge clk);
        chk("lit_s1_chan2", ev_chan, 2); chk("lit_s1_new2", ev_new, 5);
        @(negedge clk);
        chk("lit_s1_idle_valid", ev_valid, 0); chk("lit_s1_idle_busy", busy, 0);
        tick();

        // single change, two-cycle latency
        setch(0, 7);
        @(posedge clk);
        @(negedge clk);
        chk("lit_s2_valid_e0", ev_valid, 0);
        @(negedge clk);
        chk("lit_s2_valid", ev_valid, 1); chk("lit_s2_old", ev_old, 3); chk("lit_s2_new", ev_new, 7);
        @(negedge clk);
        chk("lit_s2_busy", busy, 0);
        tick();

        // FIFO fills, one coalesced change
        ev_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            setch(0, 20 + k);
            tick();
        end
        @(negedge clk);
        chk("lit_s3_count", ev_count, 8); chk("lit_s3_drop", drop_cnt, 1); chk("lit_s3_busy", busy, 1);
        tick();
        ev_ready = 1'b1;
        n_ev = 0; last_o = -1; last_n = -1; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (ev_valid) begin
                n_ev++; last_o = int'(ev_old); last_n = int'(ev_new);
            end else begin
                done = 1'b1;
            end
        end
        chk("lit_s3_nev", n_ev, 9); chk("lit_s3_last_old", last_o, 27); chk("lit_s3_last_new", last_n, 29);
        tick();

        // change on the edge the pending event is enqueued
        setch(1, 8);
        @(posedge clk);
        #2 setch(1, 9);
        @(negedge clk);
        @(negedge clk);
        chk("lit_s4_old_a", ev_old, 4); chk("lit_s4_new_a", ev_new, 8);
        @(negedge clk);
        chk("lit_s4_chan", ev_chan, 1); chk("lit_s4_old_b", ev_old, 8); chk("lit_s4_new_b", ev_new, 9);
        chk("lit_s4_drop", drop_cnt, 1);
        tick();

        // disabled channel tracks silently
        ch_en[2] = 1'b0;
        setch(2, 6); tick();
        setch(2, 9); tick(); tick();
        @(negedge clk);
        chk("lit_s5_busy", busy, 0); chk("lit_s5_count", ev_count, 0);
        tick();
        ch_en[2] = 1'b1;
        setch(2, 1);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("lit_s5_chan", ev_chan, 2); chk("lit_s5_old", ev_old, 9); chk("lit_s5_new", ev_new, 1);
        tick(); tick();

        // reset discards queued events immediately
        ev_ready = 1'b0;
        setch(0, 1); setch(1, 2); setch(2, 3);
        tick();
        setch(0, 4);
        repeat (6) tick();
        @(negedge clk);
        chk("lit_s6_count", ev_count, 4);
        tick();
        rst = 1'b1;
        #1;
        chk("lit_s6_valid", ev_valid, 0); chk("lit_s6_count0", ev_count, 0); chk("lit_s6_drop", drop_cnt, 0);
        tick();
        rst = 1'b0;

        // drop counter saturation
        for (int k = 0; k < 300; k++) begin
            setch(0, (k % 2 == 0) ? 10 : 11);
            tick();
        end
        @(negedge clk);
        chk("lit_sat_drop", drop_cnt, 255);
        ev_ready = 1'b1;
        repeat (15) tick();
        rst = 1'b1; tick(); rst = 1'b0;

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0) setch(i, int'($urandom_range(0, 63)));
            ch_en = ($urandom_range(0, 7) == 0) ? N'($urandom) : '1;
            if (c % 500 < 100) ev_ready = ($urandom_range(0, 5) == 0);
            else               ev_ready = ($urandom_range(0, 3) != 0);
            if (c == 2345) rst = 1'b1;
            if (c == 2347) rst = 1'b0;
            tick();
        end
        ev_ready = 1'b1;
        repeat (20) tick();
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
